// File: rtl/div_issue_queue.sv
//------------------------------------------------------------------------------
// div_issue_queue
//   Request FIFO and one-at-a-time issue controller in front of the radix-2
//   divider. Requests are buffered on a valid/ready handshake and issued as a
//   single-cycle div_valid_in pulse only when the divider is free and idle.
//   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_issue_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic             in_sign,
    input  logic             div_free,
    input  logic             div_done,
    output logic             div_valid_in,
    output logic [WIDTH-1:0] div_zdividend,
    output logic [WIDTH-1:0] div_zdivisor,
    output logic             div_sign,
    output logic             busy,
    output logic [CNTW-1:0]  count
);

    localparam int PTRW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q, count_d;
    logic              div_valid_in_q, div_valid_in_d;
    logic [WIDTH-1:0]  div_zdividend_q, div_zdividend_d;
    logic [WIDTH-1:0]  div_zdivisor_q, div_zdivisor_d;
    logic              div_sign_q, div_sign_d;

    // FIFO storage; contents need no reset because count gates every read
    logic [WIDTH-1:0]  fifo_dividend_q [DEPTH];
    logic [WIDTH-1:0]  fifo_divisor_q  [DEPTH];
    logic              fifo_sign_q     [DEPTH];

    logic push;
    logic pop;
    logic start;

    // Handshake and issue decisions; in_ready depends only on registered count
    always_comb begin
        in_ready = (count_q != CNTW'(DEPTH));
        push     = in_valid & in_ready;
        // The head entry leaves the FIFO during the one-cycle ISSUE state
        pop      = (state_q == S_ISSUE);
        // An entry pushed into an empty FIFO is only visible via count next cycle
        start    = (state_q == S_IDLE) && (count_q != '0) && div_free;
    end

    // Next-state for pointers, occupancy, FSM and registered divider outputs
    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        state_d         = state_q;
        div_valid_in_d  = 1'b0;
        div_zdividend_d = div_zdividend_q;
        div_zdivisor_d  = div_zdivisor_q;
        div_sign_d      = div_sign_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTRW'(DEPTH - 1)) ? '0 : wr_ptr_q + PTRW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTRW'(DEPTH - 1)) ? '0 : rd_ptr_q + PTRW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNTW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNTW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d         = S_ISSUE;
                    div_valid_in_d  = 1'b1;
                    div_zdividend_d = fifo_dividend_q[rd_ptr_q];
                    div_zdivisor_d  = fifo_divisor_q[rd_ptr_q];
                    div_sign_d      = fifo_sign_q[rd_ptr_q];
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // div_done outside WAIT never reaches this branch, so it is ignored
                if (div_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            div_valid_in_q  <= 1'b0;
            div_zdividend_q <= '0;
            div_zdivisor_q  <= '0;
            div_sign_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            div_valid_in_q  <= div_valid_in_d;
            div_zdividend_q <= div_zdividend_d;
            div_zdivisor_q  <= div_zdivisor_d;
            div_sign_q      <= div_sign_d;
        end
    end

    // FIFO write port
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dividend_q[wr_ptr_q] <= in_dividend;
            fifo_divisor_q[wr_ptr_q]  <= in_divisor;
            fifo_sign_q[wr_ptr_q]     <= in_sign;
        end
    end

    assign div_valid_in  = div_valid_in_q;
    assign div_zdividend = div_zdividend_q;
    assign div_zdivisor  = div_zdivisor_q;
    assign div_sign      = div_sign_q;
    assign busy          = (state_q != S_IDLE);
    assign count         = count_q;

endmodule

`default_nettype wire

// File: tb/tb_div_issue_queue.sv
//------------------------------------------------------------------------------
// tb_div_issue_queue
//   Randomised plus directed stimulus; accepted requests go into a scoreboard
//   queue, a negedge monitor pops and compares on every issue pulse and checks
//   occupancy, ready, busy and issue timing against an abstract model.
//   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_div_issue_queue;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNTW  = 3;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic             in_sign;
    logic             div_free;
    logic             div_done;
    logic             div_valid_in;
    logic [WIDTH-1:0] div_zdividend;
    logic [WIDTH-1:0] div_zdivisor;
    logic             div_sign;
    logic             busy;
    logic [CNTW-1:0]  count;

    div_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .in_sign      (in_sign),
        .div_free     (div_free),
        .div_done     (div_done),
        .div_valid_in (div_valid_in),
        .div_zdividend(div_zdividend),
        .div_zdivisor (div_zdivisor),
        .div_sign     (div_sign),
        .busy         (busy),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] dd;
        logic [WIDTH-1:0] dv;
        logic             sg;
    } req_t;

    req_t sb[$];

    int total = 0;
    int bad   = 0;

    // Abstract model state
    int               n_pushed      = 0;
    int               n_issued      = 0;
    bit               waiting       = 0;   // an issued op has not yet seen done
    bit               expect_issue  = 0;   // an issue pulse is due this cycle
    bit               issue_pending = 0;   // hand-off from monitor to divider model
    logic [WIDTH-1:0] exp_dd        = '0;
    logic [WIDTH-1:0] exp_dv        = '0;
    logic             exp_sg        = 1'b0;

    // Divider model controls
    bit hold_free   = 0;
    bit rand_free   = 0;
    bit spurious_en = 0;
    int lat_min     = 35;
    int lat_max     = 35;
    bit outstanding = 0;
    int lat_cnt     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        case ($urandom % 8)
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // Divider stand-in: done after a programmable latency, optional spurious done
    initial begin
        div_free = 1'b1;
        div_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                outstanding = 0;
                div_done    = 1'b0;
                div_free    = 1'b1;
                continue;
            end
            div_done = 1'b0;
            if (issue_pending) begin
                issue_pending = 0;
                outstanding   = 1;
                lat_cnt       = $urandom_range(lat_max, lat_min);
            end
            if (outstanding) begin
                if (lat_cnt == 0) begin
                    div_done    = 1'b1;
                    outstanding = 0;
                end else begin
                    lat_cnt--;
                end
            end else if (spurious_en && (($urandom % 16) == 0)) begin
                div_done = 1'b1;
            end
            div_free = !outstanding && !hold_free && (!rand_free || (($urandom % 4) != 0));
        end
    end

    // Monitor: compares every cycle at the falling edge
    initial begin : monitor
        req_t e;
        int   cnt_m;
        bit   issue_now;
        bit   idle_c;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            check("issue_pulse", 64'(div_valid_in), 64'(expect_issue));
            issue_now = div_valid_in;
            if (issue_now) begin
                if (sb.size() == 0) begin
                    fail_now("issue_from_empty");
                end else begin
                    e      = sb.pop_front();
                    exp_dd = e.dd;
                    exp_dv = e.dv;
                    exp_sg = e.sg;
                end
                issue_pending = 1;
            end
            check("dividend", 64'(div_zdividend), 64'(exp_dd));
            check("divisor", 64'(div_zdivisor), 64'(exp_dv));
            check("sign", 64'(div_sign), 64'(exp_sg));
            cnt_m = n_pushed - n_issued;
            check("count", 64'(count), 64'(cnt_m));
            check("in_ready", 64'(in_ready), 64'(cnt_m != DEPTH));
            check("busy", 64'(busy), 64'(issue_now || waiting));
            idle_c       = !issue_now && !waiting;
            expect_issue = idle_c && (cnt_m != 0) && div_free;
            if (issue_now) begin
                n_issued++;
                waiting = 1;
            end else if (waiting && div_done) begin
                waiting = 0;
            end
        end
    end

    task automatic accept_if_taken();
        if (in_valid && in_ready) begin
            sb.push_back('{in_dividend, in_divisor, in_sign});
            n_pushed++;
        end
    endtask

    task automatic push_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        int  guard = 0;
        bit  taken = 0;
        while (!taken) begin
            @(posedge clk);
            #1;
            in_valid    = 1'b1;
            in_dividend = a;
            in_divisor  = b;
            in_sign     = s;
            #6;
            if (in_ready) taken = 1;
            accept_if_taken();
            guard++;
            if (!taken && guard > 200) begin
                fail_now("push_timeout");
                taken = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((sb.size() != 0 || waiting || outstanding) && k < budget) begin
            idle(1);
            k++;
        end
        if (k >= budget) fail_now("drain_timeout");
        idle(2);
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", 64'(div_valid_in), 64'(0));
        check("rst_dividend", 64'(div_zdividend), 64'(0));
        check("rst_divisor", 64'(div_zdivisor), 64'(0));
        check("rst_sign", 64'(div_sign), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
    endtask

    task automatic clear_model();
        sb.delete();
        n_pushed      = 0;
        n_issued      = 0;
        waiting       = 0;
        expect_issue  = 0;
        issue_pending = 0;
        exp_dd        = '0;
        exp_dv        = '0;
        exp_sg        = 1'b0;
    endtask

    // Watchdog
    initial begin
        #2_000_000;
        fail_now("watchdog");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // Main stimulus
    initial begin
        int  k;
        int  pct;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        in_sign     = 1'b0;
        #3;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single unsigned request
        push_req(32'd100, 32'd7, 1'b0);
        wait_drain(200);

        // Signed pass-through and divide by zero
        push_req(32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        push_req(32'h1234_5678, 32'h0000_0000, 1'b0);
        wait_drain(200);

        // Fill and drain: five back-to-back with a 36-cycle divider
        for (int i = 0; i < 5; i++) push_req(32'(1000 + i), 32'(3 + i), i[0]);
        wait_drain(1000);

        // Divider not free with two queued, spurious done pulses in IDLE
        spurious_en = 1;
        hold_free   = 1;
        push_req(32'd55, 32'd5, 1'b0);
        push_req(32'd66, 32'd6, 1'b1);
        idle(6);
        hold_free = 0;
        lat_min   = 0;
        lat_max   = 4;
        wait_drain(400);

        // Randomised traffic: bursty pushes, random latency and free
        rand_free = 1;
        lat_min   = 0;
        lat_max   = 12;
        for (int blk = 0; blk < 15; blk++) begin
            pct = $urandom_range(95, 10);
            for (int c = 0; c < 100; c++) begin
                @(posedge clk);
                #1;
                in_valid    = (($urandom % 100) < pct);
                in_dividend = rand_word();
                in_divisor  = rand_word();
                in_sign     = 1'($urandom);
                #6;
                accept_if_taken();
            end
        end
        wait_drain(2000);

        // Reset in WAIT with three entries queued
        rand_free   = 0;
        spurious_en = 0;
        lat_min     = 35;
        lat_max     = 35;
        for (int i = 0; i < 4; i++) push_req(32'(77 + i), 32'(9 + i), 1'b0);
        in_valid = 1'b0;
        k = 0;
        while (!(waiting && (n_pushed - n_issued) == 3) && k < 30) begin
            idle(1);
            k++;
        end
        if (k >= 30) fail_now("reach_wait3");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        clear_model();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        push_req(32'hDEAD_BEEF, 32'h0000_0011, 1'b1);
        wait_drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_issue_queue.md
# div_issue_queue

Request buffer and issue controller that sits directly upstream of the radix-2 divider top. It accepts divide requests on a valid/ready handshake into a DEPTH-entry FIFO. It presents them to the divider one at a time as a single-cycle `valid_in` pulse, and only issues when the divider reports `free` and no operation is in flight. The divider's `done` pulse closes each operation, so back-to-back upstream traffic never overruns the divider.

## Interface
- WIDTH, 32, operand width; must match the divider's WIDTH
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNTW, 3, width of `count`; must equal log2(DEPTH)+1
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream request valid
- in_ready  out  1  FIFO can accept (= not full)
- in_dividend  in  WIDTH  dividend
- in_divisor  in  WIDTH  divisor
- in_sign  in  1  1 = signed divide
- div_free  in  1  divider `free` output
- div_done  in  1  divider `done` pulse
- div_valid_in  out  1  one-cycle issue pulse to divider `valid_in`
- div_zdividend  out  WIDTH  to divider `zdividend`
- div_zdivisor  out  WIDTH  to divider `zdivisor`
- div_sign  out  1  to divider `sign`
- busy  out  1  operation in flight (issued, `div_done` not yet seen)
- count  out  CNTW  FIFO occupancy, 0..DEPTH

## Operation
- FIFO: circular buffer with log2(DEPTH)-bit read/write pointers, wrapping to 0 after DEPTH-1, plus a separate occupancy counter.
- Push: `in_valid & in_ready` writes {dividend, divisor, sign}.
- Pop: occurs only on issue.
- Full: `in_ready`=0, and `in_valid` is ignored.
- Empty: no issue.
- Simultaneous push and pop: occupancy unchanged, and both pointers advance.
- Full case: `in_ready` is combinational from `count`. A pop in the same cycle does not raise `in_ready`, so there is no full-bypass.
- Empty case: no write-through. An entry pushed into an empty FIFO is issued no earlier than the next cycle.
- FSM:
  - IDLE → ISSUE when count≠0 & div_free.
  - ISSUE lasts exactly one cycle: `div_valid_in`=1, head entry popped, operand registers loaded. ISSUE → WAIT unconditionally.
  - WAIT → IDLE on `div_done`=1.
- `busy` = (state≠IDLE).
- Operand outputs are registered. They are loaded on entering ISSUE and held stable through WAIT until the next issue. `div_valid_in` is registered.
- `div_done` outside WAIT is ignored; a spurious pulse has no effect.
- `div_free` is ignored outside IDLE. Deassertion during WAIT is expected.
- No arithmetic is performed; operands pass bit-exact. Divide-by-zero and sign handling belong to the divider.

## Timing
- Reset (async assert, sync-released by the system): state=IDLE, both pointers=0, count=0, in_ready=1, div_valid_in=0, div_zdividend=0, div_zdivisor=0, div_sign=0, busy=0.
- Reset asserted mid-operation clears the queue and FSM immediately. Queued and in-flight requests are dropped. The divider is reset by the same rst_n.
- Latency, empty queue and idle divider with div_free=1:
  - push accepted at edge E;
  - `div_valid_in` high for cycle E+1 to E+2, with operands valid in the same cycle;
  - count returns to 0 at edge E+2.
- Issue rate: at most one per divider operation. The next `div_valid_in` comes no earlier than one cycle after the cycle in which `div_done` was sampled high in WAIT.
- The divider samples operands on the same edge that ends the `div_valid_in` cycle.
- `in_ready` reflects the registered count; it does not depend on `in_valid` in the same cycle.

## Test plan
- Single request: push 100/7 unsigned → one `div_valid_in` pulse exactly one cycle after acceptance. div_zdividend=100, div_zdivisor=7, div_sign=0. `busy` stays 1 until the done pulse, then returns to 0. count returns to 0.
- Fill and drain: push 5 requests back-to-back (DEPTH=4) with divider idle → one issues immediately. `in_ready` drops when count=4. Drive a done pulse 36 cycles after each issue → all requests issue in FIFO order, exactly one pulse per done.
- Signed and pass-through: push 0xFFFFFFF9 / 0x00000002 with sign=1 → outputs carry identical bits and div_sign=1. Also push divisor=0 → the request issues normally with divisor 0.
- Simultaneous push/pop: count=2; issue coincides with a new push → count stays 2, and the read and write pointers both advance, including wrap from 3 to 0.
- Divider not free: hold div_free=0 with 2 entries queued → no issue. Raise div_free → an issue occurs on the next cycle. A spurious div_done in IDLE → no state change.
- Reset mid-WAIT with 3 queued: assert rst_n=0 → all outputs take their reset values immediately, count=0. After release, a new request issues within 1 cycle.
